// File: rtl/usart_rx_fifo.sv
// Asynchronous serial receiver with a configurable frame format, mid-bit sampling,
// sticky error flags, and a first-word-fall-through receive FIFO that the CPU pops.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s to fall
// START  | half-bit wait, then confirm the start bit (high = glitch)
// DATA   | sampling DATA_BITS bits at bit centres, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit(s); the last sample commits the frame
module usart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int OUT_W        = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          controle,
  input  logic                          limpar_erros,
  output logic [OUT_W-1:0]              dado,
  output logic                          dado_pronto,
  output logic                          habilitar,
  output logic                          erro_paridade,
  output logic                          erro_quadro,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   contagem
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frm_bad_q, frm_bad_d;
  logic                 rx_m_q, rx_s_q;
  logic                 ctl_q;
  logic                 err_par_q, err_par_d;
  logic                 err_frm_q, err_frm_d;
  logic                 ovf_q, ovf_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic tick, push, pop, set_par, set_frm, set_ovf, frm_bad_now, last_stop;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    frm_bad_d   = frm_bad_q;
    push        = 1'b0;
    set_par     = 1'b0;
    set_frm     = 1'b0;
    set_ovf     = 1'b0;
    tick        = (tmr_q == '0);
    frm_bad_now = frm_bad_q | ~rx_s_q;
    last_stop   = (STOP_BITS == 1) || stop_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          tmr_d     = HALF_LOAD;
          bit_d     = '0;
          stop_d    = 1'b0;
          par_bad_d = 1'b0;
          frm_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          tmr_d   = FULL_LOAD;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          tmr_d   = FULL_LOAD;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          tmr_d     = FULL_LOAD;
          par_bad_d = ((^shift_q) ^ rx_s_q) != (PARITY_MODE == 2);
          state_d   = S_STOP;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          tmr_d     = FULL_LOAD;
          frm_bad_d = frm_bad_now;
          if (last_stop) begin
            // Commit: errors drop the frame; a good frame needs FIFO space.
            state_d = S_IDLE;
            set_par = par_bad_q;
            set_frm = frm_bad_now;
            if (!par_bad_q && !frm_bad_now) begin
              if (cnt_q == FULL_CNT) set_ovf = 1'b1;
              else                   push    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = controle & ~ctl_q & (cnt_q != '0);
    err_par_d = set_par | (err_par_q & ~limpar_erros);
    err_frm_d = set_frm | (err_frm_q & ~limpar_erros);
    ovf_d     = set_ovf | (ovf_q & ~limpar_erros);
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d     = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      frm_bad_q <= 1'b0;
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      ctl_q     <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      frm_bad_q <= frm_bad_d;
      rx_m_q    <= rx;
      rx_s_q    <= rx_m_q;
      ctl_q     <= controle;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign dado          = (cnt_q != '0) ? OUT_W'(mem_q[rd_ptr_q]) : '0;
  assign dado_pronto   = (cnt_q != '0);
  assign habilitar     = (state_q != S_IDLE);
  assign erro_paridade = err_par_q;
  assign erro_quadro   = err_frm_q;
  assign overflow      = ovf_q;
  assign contagem      = cnt_q;

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Directed bench for usart_rx_fifo: a no-parity instance (A) and an even-parity
// instance (B), driven with hand-built serial frames at 16 clocks per bit.
module tb_usart_rx_fifo;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx_a, ctl_a, clr_a, rx_b, ctl_b, clr_b;
  logic [31:0] dado_a, dado_b;
  logic pronto_a, hab_a, perr_a, ferr_a, ovf_a;
  logic pronto_b, hab_b, perr_b, ferr_b, ovf_b;
  logic [3:0] cnt_a, cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usart_rx_fifo #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .controle(ctl_a), .limpar_erros(clr_a),
    .dado(dado_a), .dado_pronto(pronto_a), .habilitar(hab_a),
    .erro_paridade(perr_a), .erro_quadro(ferr_a), .overflow(ovf_a),
    .contagem(cnt_a));

  usart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .controle(ctl_b), .limpar_erros(clr_b),
    .dado(dado_b), .dado_pronto(pronto_b), .habilitar(hab_b),
    .erro_paridade(perr_b), .erro_quadro(ferr_b), .overflow(ovf_b),
    .contagem(cnt_b));

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_dado;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Called at a negedge; frame bits change on negedges, 16 clocks each.
  task automatic send(input bit sel, input logic [7:0] data, input bit use_par,
                      input bit par, input bit stop_v, input bit chk_lat);
    logic [10:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (use_par) begin
      bits[9] = par;
      bits[10] = stop_v;
      n = 11;
    end else begin
      bits[9] = stop_v;
      n = 10;
    end
    for (int i = 0; i < n; i++) begin
      drive(sel, bits[i]);
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (chk_lat && i == n - 1 && j == 9) chk("pronto_before_commit", 32'(pronto_a), 32'd0);
        if (chk_lat && i == n - 1 && j == 10) begin
          chk("pronto_after_commit", 32'(pronto_a), 32'd1);
          chk("hab_after_commit", 32'(hab_a), 32'd0);
        end
      end
    end
    drive(sel, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_a();
    ctl_a = 1'b1;
    @(negedge clk);
    ctl_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear(input bit sel);
    if (sel) clr_b = 1'b1; else clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{8'hA5, 32'h0000_00A5};
    vecs[1] = '{8'h00, 32'h0000_0000};
    vecs[2] = '{8'hFF, 32'h0000_00FF};
    vecs[3] = '{8'h3C, 32'h0000_003C};
    vecs[4] = '{8'h81, 32'h0000_0081};

    rst = 1'b0;
    rx_a = 1'b1; ctl_a = 1'b0; clr_a = 1'b0;
    rx_b = 1'b1; ctl_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dado", dado_a, 32'd0);
    chk("rst_pronto", 32'(pronto_a), 32'd0);
    chk("rst_hab", 32'(hab_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_flags", {29'd0, perr_a, ferr_a, ovf_a}, 32'd0);
    chk("rst_b_flags", {29'd0, perr_b, ferr_b, ovf_b}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Test 1: 0xA5 with exact commit latency, then pop to empty
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t1_dado", dado_a, 32'h0000_00A5);
    chk("t1_cnt", 32'(cnt_a), 32'd1);
    pop_a();
    chk("t1_pronto_pop", 32'(pronto_a), 32'd0);
    chk("t1_dado_pop", dado_a, 32'd0);

    // Table of single frames, each received and popped
    for (int k = 0; k < 5; k++) begin
      send(1'b0, vecs[k].data, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("vec_dado", dado_a, vecs[k].exp_dado);
      chk("vec_cnt", 32'(cnt_a), 32'd1);
      pop_a();
      chk("vec_empty", 32'(cnt_a), 32'd0);
    end
    // Holding controle high pops only once
    send(1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    ctl_a = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_one_pop_cnt", 32'(cnt_a), 32'd1);
    chk("hold_one_pop_dado", dado_a, 32'h22);
    ctl_a = 1'b0;
    @(negedge clk);
    pop_a();

    // Test 2: overflow with 9 frames
    for (int k = 0; k < 9; k++) send(1'b0, 8'(8'h11 + k), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_cnt", 32'(cnt_a), 32'd8);
    chk("t2_ovf", 32'(ovf_a), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_pop_order", dado_a, 32'(8'h11 + k));
      pop_a();
    end
    chk("t2_empty", 32'(pronto_a), 32'd0);
    clear(1'b0);
    chk("t2_ovf_clr", 32'(ovf_a), 32'd0);

    // Test 3: even parity on instance B
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_perr", 32'(perr_b), 32'd1);
    chk("t3_empty", 32'(pronto_b), 32'd0);
    clear(1'b1);
    chk("t3_perr_clr", 32'(perr_b), 32'd0);
    send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_dado", dado_b, 32'h03);
    chk("t3_perr_good", 32'(perr_b), 32'd0);

    // Test 4: framing error then a good frame
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_ferr", 32'(ferr_a), 32'd1);
    chk("t4_nopush", 32'(cnt_a), 32'd0);
    send(1'b0, 8'h5B, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_dado", dado_a, 32'h5B);
    chk("t4_cnt", 32'(cnt_a), 32'd1);
    pop_a();
    clear(1'b0);
    chk("t4_ferr_clr", 32'(ferr_a), 32'd0);

    // Test 5: 4-cycle glitch
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_hab_during", 32'(hab_a), 32'd1);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_hab_after", 32'(hab_a), 32'd0);
    chk("t5_nopush", 32'(cnt_a), 32'd0);
    chk("t5_flags", {29'd0, perr_a, ferr_a, ovf_a}, 32'd0);

    // Test 6: reset midway through DATA of 0x77 with two words queued
    send(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_queued", 32'(cnt_a), 32'd2);
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("t6_hab_mid", 32'(hab_a), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_dado", dado_a, 32'd0);
    chk("t6_rst_pronto", 32'(pronto_a), 32'd0);
    chk("t6_rst_hab", 32'(hab_a), 32'd0);
    chk("t6_rst_cnt", 32'(cnt_a), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send(1'b0, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_cnt", 32'(cnt_a), 32'd1);
    chk("t6_dado", dado_a, 32'h42);
    pop_a();
    chk("t6_empty", 32'(pronto_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
